// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   XLEN_DEF / NREG_DEF / NRD_DEF : default width, depth and read-port count
//   clr_state_e                   : bulk-clear sequencer states
//   aw_of()                       : register-index width for a given depth
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port of regfile_sb.
//   regs, busy          : storage and scoreboard snapshot from the top
//   rd_addr             : register index for this port
//   rd_data, rd_ready   : operand value and "not waiting on a producer"
// Optional macro REGFILE_BYPASS_EN adds the same-cycle commit forward:
//   wr_fwd/wr_addr/wr_data : qualified commit (already excludes x0 and clear)
//   iss_go/iss_addr        : qualified issue, which keeps ready low on a hit
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = aw_of(NREG_DEF)
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic [AW-1:0]             rd_addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                      wr_fwd,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic                      iss_go,
  input  logic [AW-1:0]             iss_addr,
`endif
  output logic [XLEN-1:0]           rd_data,
  output logic                      rd_ready
);

  always_comb begin
    rd_data  = regs[rd_addr];
    rd_ready = !busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_fwd && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
      // A same-cycle issue to this register is a newer producer, so the
      // stored busy bit keeps governing readiness.
      if (!(iss_go && (iss_addr == rd_addr))) rd_ready = 1'b1;
    end
`endif
    if (rd_addr == '0) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file with per-register busy bits
// and a sequenced bulk-clear engine.
//   clk, rst (async, active-low)
//   wr_en/wr_addr/wr_data : commit from writeback, clears busy
//   iss_en/iss_addr       : issue, sets busy on the destination
//   flush                 : clears every busy bit
//   rd_addr/rd_data/rd_ready : NRD packed combinational read ports
//   clr_req/clr_busy/clr_done : bulk clear of x1..x(NREG-1), one per cycle
// Macro REGFILE_BYPASS_EN enables commit-to-read forwarding in each port.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  localparam int AW   = aw_of(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_ready,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, busy_nxt;
  clr_state_e                state, state_nxt;
  logic [AW-1:0]             idx, idx_nxt;
  logic                      done_nxt;
  logic                      wr_go, iss_go;

  assign clr_busy = (state == CLEAR);
  // Commits and issues are dropped while clearing; x0 is never a target.
  assign wr_go    = wr_en  && !clr_busy && (wr_addr  != '0);
  assign iss_go   = iss_en && !clr_busy && (iss_addr != '0);

  // Clear sequencer
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (clr_req) begin
        state_nxt = CLEAR;
        idx_nxt   = AW'(1);
      end
      CLEAR: begin
        idx_nxt = idx + AW'(1);
        if (idx == AW'(NREG-1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      clr_done <= done_nxt;
    end
  end

  // Scoreboard: later assignments win, giving issue priority over a
  // same-cycle commit and flush priority over everything.
  always_comb begin
    busy_nxt = busy;
    if (clr_busy) busy_nxt[idx]      = 1'b0;
    if (wr_go)    busy_nxt[wr_addr]  = 1'b0;
    if (iss_go)   busy_nxt[iss_addr] = 1'b1;
    if (flush)    busy_nxt           = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (clr_busy)   regs[idx]     <= '0;
      else if (wr_go) regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .regs     (regs),
      .busy     (busy),
      .rd_addr  (rd_addr[i*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
      .wr_fwd   (wr_go),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_go   (iss_go),
      .iss_addr (iss_addr),
`endif
      .rd_data  (rd_data[i*XLEN +: XLEN]),
      .rd_ready (rd_ready[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic                flush = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic                clr_req = 1'b0;
  logic                clr_busy;
  logic                clr_done;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ready(rd_ready), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: architectural contents, busy flags, clear progress.
  logic [XLEN-1:0] mem [NREG];
  bit              bsy [NREG];
  bit              m_clr;
  int              m_idx;
  bit              m_done;

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) begin
      mem[k] = '0;
      bsy[k] = 1'b0;
    end
    m_clr  = 1'b0;
    m_idx  = 0;
    m_done = 1'b0;
  endfunction

  function automatic void model_step();
    bit was_clr = m_clr;
    m_done = 1'b0;
    if (!was_clr) begin
      if (wr_en && wr_addr != 0) begin
        mem[wr_addr] = wr_data;
        bsy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) bsy[iss_addr] = 1'b1;
      if (clr_req) begin
        m_clr = 1'b1;
        m_idx = 1;
      end
    end else begin
      mem[m_idx] = '0;
      bsy[m_idx] = 1'b0;
      if (m_idx == NREG-1) begin
        m_clr  = 1'b0;
        m_done = 1'b1;
      end else m_idx++;
    end
    if (flush) for (int k = 0; k < NREG; k++) bsy[k] = 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !m_clr && int'(wr_addr) == a) return wr_data;
`endif
    return mem[a];
  endfunction

  function automatic logic exp_rdy(int a);
    if (a == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !m_clr && int'(wr_addr) == a && !(iss_en && int'(iss_addr) == a))
      return 1'b1;
`endif
    return !bsy[a];
  endfunction

  // Advance one clock; inputs are held from the previous falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    model_reset();
    rd_addr = {AW'(31), AW'(5)};
    #1;
    n_chk++;
    if (rd_data !== '0 || rd_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_read_low: data=%h ready=%b want 0/11", rd_data, rd_ready);
    end
    n_chk++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clr: busy=%b done=%b want 0/0", clr_busy, clr_done);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_chk++;
    if (rd_data !== '0 || rd_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_read_high: data=%h ready=%b want 0/11", rd_data, rd_ready);
    end
  endtask

  task automatic test_issue_commit();
    iss_en = 1'b1; iss_addr = AW'(7);
    tick();
    iss_en = 1'b0;
    rd_addr = {AW'(7), AW'(7)};
    #1;
    n_chk++;
    if (rd_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL issue_busy: ready=%b want 00", rd_ready);
    end
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'hDEADBEEF;
    #1;
    n_chk++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data !== {2{32'hDEADBEEF}} || rd_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL commit_fwd: data=%h ready=%b want deadbeef x2/11", rd_data, rd_ready);
    end
`else
    if (rd_data !== '0 || rd_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL commit_same_cycle: data=%h ready=%b want 0/00", rd_data, rd_ready);
    end
`endif
    tick();
    wr_en = 1'b0;
    #1;
    n_chk++;
    if (rd_data !== {2{32'hDEADBEEF}} || rd_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL commit_next: data=%h ready=%b want deadbeef x2/11", rd_data, rd_ready);
    end
  endtask

  task automatic test_collision();
    iss_en = 1'b1; iss_addr = AW'(3);
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'h55;
    tick();
    idle_inputs();
    rd_addr = {AW'(3), AW'(0)};
    #1;
    n_chk++;
    if (rd_data[XLEN +: XLEN] !== 32'h55 || rd_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL collision: data=%h ready=%b want 55/0", rd_data[XLEN +: XLEN], rd_ready[1]);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_chk++;
    if (rd_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: ready=%b want 1", rd_ready[1]);
    end
  endtask

  task automatic test_reg0();
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = '0;
    tick();
    idle_inputs();
    rd_addr = '0;
    #1;
    n_chk++;
    if (rd_data !== '0 || rd_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reg0: data=%h ready=%b want 0/11", rd_data, rd_ready);
    end
  endtask

  task automatic test_random();
    int ra [NRD];
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom_range(0, NREG-1));
      wr_data  = $urandom;
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREG-1));
      flush    = ($urandom_range(0, 15) == 0);
      clr_req  = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < NRD; p++) begin
        case ($urandom_range(0, 3))
          0:       ra[p] = int'(wr_addr);
          1:       ra[p] = int'(iss_addr);
          default: ra[p] = int'($urandom_range(0, NREG-1));
        endcase
        rd_addr[p*AW +: AW] = AW'(ra[p]);
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_chk++;
        if (rd_data[p*XLEN +: XLEN] !== exp_data(ra[p]) || rd_ready[p] !== exp_rdy(ra[p])) begin
          n_fail++;
          $display("FAIL rand_read c=%0d p=%0d x%0d: data=%h ready=%b want %h/%b", c, p, ra[p],
                   rd_data[p*XLEN +: XLEN], rd_ready[p], exp_data(ra[p]), exp_rdy(ra[p]));
        end
      end
      tick();
      n_chk++;
      if (clr_busy !== m_clr || clr_done !== m_done) begin
        n_fail++;
        $display("FAIL rand_clr c=%0d: busy=%b done=%b want %b/%b", c, clr_busy, clr_done, m_clr, m_done);
      end
    end
    idle_inputs();
    for (int c = 0; c < 40 && (m_clr || m_done); c++) tick();
  endtask

  task automatic test_bulk_clear();
    int cnt = 0;
    int dn = 0;
    for (int a = 1; a < NREG; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = $urandom | 32'h1;
      tick();
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 40 && dn == 0; c++) begin
      if (c == 5) begin
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'h1234; rd_addr = {AW'(0), AW'(5)};
      end else wr_en = 1'b0;
      #1;
      n_chk++;
      if (clr_busy !== m_clr || clr_done !== m_done) begin
        n_fail++;
        $display("FAIL clear_seq c=%0d: busy=%b done=%b want %b/%b", c, clr_busy, clr_done, m_clr, m_done);
      end
      if (c == 5) begin
        n_chk++;
        if (rd_data[XLEN-1:0] !== exp_data(5)) begin
          n_fail++;
          $display("FAIL clear_no_fwd: data=%h want %h", rd_data[XLEN-1:0], exp_data(5));
        end
      end
      if (clr_busy) cnt++;
      if (clr_done) dn++;
      tick();
    end
    wr_en = 1'b0;
    n_chk++;
    if (cnt != NREG-1 || dn != 1) begin
      n_fail++;
      $display("FAIL clear_len: busy_cycles=%0d done=%0d want %0d/1", cnt, dn, NREG-1);
    end
    n_chk++;
    if (clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done_pulse: done=%b want 0", clr_done);
    end
    for (int a = 0; a < NREG; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      n_chk++;
      if (rd_data !== '0 || rd_ready !== 2'b11) begin
        n_fail++;
        $display("FAIL clear_zero x%0d: data=%h ready=%b want 0/11", a, rd_data, rd_ready);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt = 0;
    int dn = 0;
    wr_en = 1'b1; wr_addr = AW'(20); wr_data = 32'hA5A5A5A5;
    iss_en = 1'b1; iss_addr = AW'(25);
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b0;
    model_reset();
    rd_addr = {AW'(25), AW'(20)};
    #1;
    n_chk++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_rst_clr: busy=%b done=%b want 0/0", clr_busy, clr_done);
    end
    n_chk++;
    if (rd_data !== '0 || rd_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL midclr_rst_read: data=%h ready=%b want 0/11", rd_data, rd_ready);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midclr_no_done c=%0d: busy=%b done=%b want 0/0", c, clr_busy, clr_done);
      end
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 40 && dn == 0; c++) begin
      if (clr_busy) cnt++;
      if (clr_done) dn++;
      tick();
    end
    n_chk++;
    if (cnt != NREG-1 || dn != 1) begin
      n_fail++;
      $display("FAIL midclr_rerun: busy_cycles=%0d done=%0d want %0d/1", cnt, dn, NREG-1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_issue_commit();
    test_collision();
    test_reg0();
    test_random();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
